// File: rtl/rca_loop_profiler_if.sv
// rca_loop_profiler_if: branch feed, CPU request/response channel and hot-loop exception of the profiler
interface rca_loop_profiler_if #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 3
);
   logic              br_valid;
   logic              br_taken;
   logic [ADDR_W-1:0] br_pc;
   logic [20:0]       br_offset;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [IDX_W-1:0]  req_index;
   logic [1:0]        req_field;
   logic [31:0]       req_data;
   logic [2:0]        req_id;
   logic              rsp_valid;
   logic              rsp_ack;
   logic [31:0]       rsp_data;
   logic [2:0]        rsp_id;
   logic              prof_exception;
   logic [IDX_W-1:0]  exc_index;

   modport master (
      output br_valid, br_taken, br_pc, br_offset,
      output req_valid, req_op, req_index, req_field, req_data, req_id, rsp_ack,
      input  req_ready, rsp_valid, rsp_data, rsp_id, prof_exception, exc_index
   );

   modport slave (
      input  br_valid, br_taken, br_pc, br_offset,
      input  req_valid, req_op, req_index, req_field, req_data, req_id, rsp_ack,
      output req_ready, rsp_valid, rsp_data, rsp_id, prof_exception, exc_index
   );
endinterface

// File: rtl/rca_loop_profiler.sv
// rca_loop_profiler: fully-associative hot-loop table of short-backward branch PCs with decay and hot exception
module rca_loop_profiler #(
   parameter int NUM_ENTRIES       = 8,
   parameter int COUNT_W           = 8,
   parameter int ADDR_W            = 32,
   parameter int SBB_MAX_BACK      = 256,
   parameter int DECAY_W           = 16,
   parameter int DEFAULT_THRESHOLD = 64,
   parameter int DEFAULT_DECAY     = 4096
) (
   input logic                clk,
   input logic                rst,
   rca_loop_profiler_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   logic [ADDR_W-1:0]      pc_q  [NUM_ENTRIES];
   logic [ADDR_W-1:0]      pc_d  [NUM_ENTRIES];
   logic [COUNT_W-1:0]     cnt_q [NUM_ENTRIES];
   logic [COUNT_W-1:0]     cnt_d [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] vld_q, vld_d, hot, hot_r, rise;
   logic                   lock_q, lock_d;
   logic [COUNT_W-1:0]     thr_q, thr_d, min_cnt;
   logic [DECAY_W-1:0]     per_q, per_d, dcnt_q, dcnt_d;
   logic                   rsp_valid_q, exc_q;
   logic [31:0]            rsp_data_q, rd_data;
   logic [2:0]             rsp_id_q;
   logic [IDX_W-1:0]       exc_idx_q, hit_idx, vic_idx, rise_idx;
   logic                   accept, is_event, hit, sat, tick, halve, wr_per;
   int                     off;
   logic                   unused;

   assign unused         = ^bus.req_data;
   assign accept         = bus.req_valid & ~rsp_valid_q;
   assign off            = int'($signed(bus.br_offset));
   assign bus.req_ready  = ~rsp_valid_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.prof_exception = exc_q;
   assign bus.exc_index  = exc_idx_q;

   always_comb begin
      // clear and config writes discard a branch arriving in the same cycle
      is_event = bus.br_valid & bus.br_taken & ~lock_q & (off < 0) & (off >= -SBB_MAX_BACK)
               & ~(accept & bus.req_op[1]);
      hit      = 1'b0;
      hit_idx  = '0;
      vic_idx  = '0;
      min_cnt  = cnt_q[0];
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (vld_q[i] && pc_q[i] == bus.br_pc) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      for (int i = 1; i < NUM_ENTRIES; i++)
         if (cnt_q[i] < min_cnt) begin
            min_cnt = cnt_q[i];
            vic_idx = IDX_W'(i);
         end
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (!vld_q[i]) vic_idx = IDX_W'(i);
      sat   = is_event & hit & (cnt_q[hit_idx] == CNT_MAX);
      tick  = (per_q != '0) && (dcnt_q == per_q - 1'b1);
      halve = sat | tick;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         pc_d[i]  = pc_q[i];
         cnt_d[i] = halve ? cnt_q[i] >> 1 : cnt_q[i];
         vld_d[i] = vld_q[i] & ~(tick & (cnt_d[i] == '0));
      end
      if (is_event && hit) begin
         cnt_d[hit_idx] = cnt_d[hit_idx] + 1'b1;
         vld_d[hit_idx] = 1'b1;
      end else if (is_event) begin
         pc_d[vic_idx]  = bus.br_pc;
         cnt_d[vic_idx] = COUNT_W'(1);
         vld_d[vic_idx] = 1'b1;
      end
      if (accept && bus.req_op == 2'd3) begin
         vld_d = '0;
         for (int i = 0; i < NUM_ENTRIES; i++) cnt_d[i] = '0;
      end
      wr_per = accept && bus.req_op == 2'd2 && bus.req_field == 2'd1;
      lock_d = lock_q ^ (accept && bus.req_op == 2'd1);
      thr_d  = (accept && bus.req_op == 2'd2 && bus.req_field == 2'd0) ? COUNT_W'(bus.req_data) : thr_q;
      per_d  = wr_per ? DECAY_W'(bus.req_data) : per_q;
      dcnt_d = (wr_per || tick) ? '0 : (per_q == '0) ? dcnt_q : dcnt_q + 1'b1;
      for (int i = 0; i < NUM_ENTRIES; i++) hot[i] = vld_q[i] && cnt_q[i] >= thr_q;
      rise     = hot & ~hot_r;
      rise_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (rise[i]) rise_idx = IDX_W'(i);
      rd_data = bus.req_field == 2'd0 ? 32'(pc_q[bus.req_index]) :
                bus.req_field == 2'd1 ? 32'(vld_q[bus.req_index]) :
                bus.req_field == 2'd2 ? 32'(cnt_q[bus.req_index]) : 32'({lock_q, thr_q});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            pc_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         vld_q       <= '0;
         hot_r       <= '0;
         lock_q      <= 1'b0;
         thr_q       <= COUNT_W'(DEFAULT_THRESHOLD);
         per_q       <= DECAY_W'(DEFAULT_DECAY);
         dcnt_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         exc_q       <= 1'b0;
         exc_idx_q   <= '0;
      end else begin
         pc_q   <= pc_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
         hot_r  <= hot;
         lock_q <= lock_d;
         thr_q  <= thr_d;
         per_q  <= per_d;
         dcnt_q <= dcnt_d;
         // a rise landing right after a pulse is dropped, not deferred
         exc_q  <= |rise & ~exc_q;
         if (|rise && !exc_q) exc_idx_q <= rise_idx;
         if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= (bus.req_op == 2'd0) ? rd_data : '0;
            rsp_id_q    <= bus.req_id;
         end else if (bus.rsp_ack) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: doc/rca_loop_profiler.md
# rca_loop_profiler

Parametrised hot-loop profiler for the RCA flow. It watches taken short-backward branches from the branch unit and keeps a small fully-associative table of loop-closing branch PCs with saturating taken counters. It ages the table periodically and raises a one-cycle exception, with the entry index, when a loop becomes hot. The CPU reads entries and controls the block through an issue/writeback-style request/response handshake.

## Interface
Parameters:
- NUM_ENTRIES, 8: table depth; power of two, ≥2
- COUNT_W, 8: taken-counter width
- ADDR_W, 32: branch PC width
- SBB_MAX_BACK, 256: largest backward byte offset classed as a short backward branch
- DECAY_W, 16: decay-period register width
- DEFAULT_THRESHOLD, 64: reset value of the hot threshold
- DEFAULT_DECAY, 4096: reset value of the decay period; 0 disables decay

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- br_valid  in  1  a branch issued this cycle
- br_taken  in  1  branch taken
- br_pc  in  ADDR_W  branch instruction PC
- br_offset  in  21  signed PC-relative offset
- req_valid  in  1  CPU request
- req_ready  out  1  request accepted when both high
- req_op  in  2  0 read, 1 toggle lock, 2 write config, 3 clear table
- req_index  in  clog2(NUM_ENTRIES)  entry for read
- req_field  in  2  read: 0 PC, 1 valid, 2 count, 3 lock/threshold status; write: 0 threshold, 1 decay period
- req_data  in  32  write data
- req_id  in  ID_W(=3)  tag echoed on response
- rsp_valid  out  1  response pending
- rsp_ack  in  1  response consumed
- rsp_data  out  32  read data; 0 for non-read ops
- rsp_id  out  3  tag of the pending response
- prof_exception  out  1  one-cycle hot-loop pulse
- exc_index  out  clog2(NUM_ENTRIES)  entry that went hot

## Operation
- Event: br_valid & br_taken & ~lock & (−SBB_MAX_BACK ≤ br_offset < 0).
- Hit: a valid entry with PC == br_pc. Only one entry can match.
- Hit, count < max: count+1.
- Hit, count == max: every entry is halved (>>1), then the hit entry gets +1.
- Miss: allocate to the lowest-index invalid entry. If none is invalid, allocate to the lowest count; ties go to the lowest index. The new entry gets PC = br_pc, count = 1, valid = 1.
- Decay counter runs when period ≠ 0. When it reaches period−1 it wraps to 0 and all counts halve; an entry reaching 0 becomes invalid.
- Same-cycle ordering:
  - Halving is applied first, then the hit increment. If saturation-halving and decay coincide, halve once only.
  - A newly allocated entry is not halved or invalidated that cycle.
- Lock:
  - Freezes allocation and increment. Decay still runs.
  - Reset value is unlocked.
  - op 1 toggles the lock.
- op 2 writes the threshold (low COUNT_W bits) or the decay period (low DECAY_W bits). A decay-period write also zeroes the decay counter.
- op 3 invalidates all entries and zeroes all counts.
- Read field 3 returns {lock, threshold}, zero-extended.
- Hot detection:
  - Per entry, hot = valid & count ≥ threshold, taken from registered state; hot_r is hot delayed one cycle.
  - prof_exception = OR(hot & ~hot_r), but never on two consecutive cycles.
  - exc_index is the lowest rising index.
  - A rise that is suppressed is dropped.

## Timing
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_id=0.
  - prof_exception=0, exc_index=0.
  - Table all invalid with counts 0; lock=0.
  - Threshold=DEFAULT_THRESHOLD, decay counter 0.
- Table update: registered in the cycle after the qualifying branch.
- Exception: pulses 1 cycle after the count register crosses the threshold, i.e. 2 cycles after the branch.
- Request/response handshake:
  - req_ready = ~rsp_valid.
  - On acceptance, rsp_valid rises the next cycle, together with rsp_data and rsp_id.
  - rsp_data is sampled from table state at the acceptance edge, before any same-cycle update.
  - rsp_valid, rsp_data and rsp_id hold until rsp_ack; rsp_valid drops in the cycle after the ack.
  - The earliest next acceptance is that same cycle.
  - rsp_ack with rsp_valid low is ignored.
- Clear or config write versus a same-cycle branch: the op wins, and the branch is discarded.
- Asynchronous reset mid-response drops the pending response without an ack.

## Test plan
- Reset, then 3 taken branches at PC 0x100 with offset −16: entry0 PC=0x100, count=3; read field 2 index 0 returns 3 with the echoed id.
- Threshold=4 (op2), then 4 taken branches: exactly one prof_exception pulse, exc_index=0, 2 cycles after the 4th branch; further branches produce no pulse.
- Fill all 8 entries with counts 1..8, then a miss at PC 0x900: entry0 is replaced with count 1. Branches with offset +8 or −(SBB_MAX_BACK+4) allocate nothing.
- Drive entry2 to 255 (COUNT_W=8) with others at 10, then hit entry2: entry2=128, others=5.
- Decay period 16, one entry at count 1, no branches: after 16 cycles the entry is invalid. Lock, branch 5 times: count unchanged; unlock restores counting.
- Request while rsp_valid is held for 5 cycles without ack: req_ready stays 0 and rsp_data is stable. Ack: next request is accepted the cycle rsp_valid falls. rst low mid-response: all outputs go to reset values immediately.
